// File: rtl/mmio_expstate_irq_pkg.sv
// Shared definitions for the EXPSTATE change-detect / interrupt MMIO block.
// Contents: register byte offsets, bus FSM state type, response error codes.
package mmio_expstate_irq_pkg;

    // Word-aligned register map (byte offsets, compared against a
    // zero-extended request address).
    localparam logic [31:0] OFF_STATUS = 32'h0;
    localparam logic [31:0] OFF_EDGE   = 32'h4;
    localparam logic [31:0] OFF_MASK   = 32'h8;
    localparam logic [31:0] OFF_SWINT  = 32'hC;

    // Single-outstanding request/response engine.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } bus_state_e;

    // Response error codes carried on RSP_ERR.
    localparam logic RSP_OK         = 1'b0;
    localparam logic RSP_ERR_DECODE = 1'b1;

endpackage

// File: rtl/mmio_vec_sync.sv
// Multi-bit flop-chain synchronizer for the core's EXPSTATE bus.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset (all stages clear to 0)
//   d_i     asynchronous input vector
//   q_o     vector after STAGES flops
module mmio_vec_sync #(
    parameter int W      = 32,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/mmio_expstate_irq.sv
// MMIO peer of the core's export-state / interrupt pins.
// Synchronizes EXPSTATE, latches per-bit changes into a W1C EDGE register and
// drives the registered level interrupt BInterrupt06 from (EDGE & MASK) or SWINT.
// Ports:
//   CLK, RST_N                clock, asynchronous active-low reset
//   EXPSTATE                  export state from the core
//   REQ_VALID/READY/WRITE/ADDR/WDATA   request channel
//   RSP_VALID/READY/RDATA/ERR          response channel
//   BInterrupt06              level interrupt to the core
//   dbg_state_o               current bus FSM state
// Handshake: a request transfers on an edge where REQ_VALID && REQ_READY; a
// response transfers on an edge where RSP_VALID && RSP_READY. RSP_* stay
// stable while RSP_VALID is high, and no new request is accepted until the
// outstanding response has been consumed.
module mmio_expstate_irq
    import mmio_expstate_irq_pkg::*;
#(
    parameter int EXP_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [EXP_W-1:0]  EXPSTATE,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WRITE,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [31:0]       REQ_WDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [31:0]       RSP_RDATA,
    output logic              RSP_ERR,
    output logic              BInterrupt06,
    output bus_state_e        dbg_state_o
);

    // PREV only holds a real sample once the sync chain has filled and PREV
    // has copied it, so change detection stays off for SYNC_STAGES+1 edges.
    localparam int WARM  = SYNC_STAGES + 1;
    localparam int CNT_W = $clog2(WARM + 1);

    logic [EXP_W-1:0] sync_val;
    logic [EXP_W-1:0] prev_q, chg;
    logic [EXP_W-1:0] edge_q, edge_d, mask_q, mask_d, w1c;
    logic             swint_q, swint_d, irq_q, irq_d;
    logic [CNT_W-1:0] warm_q, warm_d;
    logic             warm_done;
    bus_state_e       state_q, state_d;
    logic [31:0]      rdata_q, rdata_d, rd_val, addr_w;
    logic             err_q, err_d;
    logic             accept, dec_err, wr_ok;
    logic             unused_wdata;

    mmio_vec_sync #(
        .W      (EXP_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .d_i    (EXPSTATE),
        .q_o    (sync_val)
    );

    assign warm_done = (warm_q == CNT_W'(WARM));
    assign warm_d    = warm_done ? warm_q : warm_q + CNT_W'(1);
    assign chg       = warm_done ? (sync_val ^ prev_q) : '0;

    // Address decode on a zero-extended copy so offsets compare at 32 bits.
    always_comb begin
        addr_w = '0;
        addr_w[ADDR_W-1:0] = REQ_ADDR;
    end

    assign dec_err = (addr_w[1:0] != 2'b00) || (addr_w > OFF_SWINT);
    assign accept  = REQ_VALID && (state_q == ST_IDLE);
    assign wr_ok   = accept && REQ_WRITE && !dec_err;
    assign unused_wdata = ^REQ_WDATA;

    // Set wins: a change in the same cycle as a W1C keeps the bit set.
    always_comb begin
        w1c     = '0;
        mask_d  = mask_q;
        swint_d = swint_q;
        if (wr_ok && addr_w == OFF_EDGE)  w1c     = REQ_WDATA[EXP_W-1:0];
        if (wr_ok && addr_w == OFF_MASK)  mask_d  = REQ_WDATA[EXP_W-1:0];
        if (wr_ok && addr_w == OFF_SWINT) swint_d = REQ_WDATA[0];
        edge_d = (edge_q & ~w1c) | chg;
        irq_d  = (|(edge_q & mask_q)) | swint_q;
    end

    always_comb begin
        rd_val = '0;
        case (addr_w)
            OFF_STATUS: rd_val[EXP_W-1:0] = sync_val;
            OFF_EDGE:   rd_val[EXP_W-1:0] = edge_q;
            OFF_MASK:   rd_val[EXP_W-1:0] = mask_q;
            OFF_SWINT:  rd_val[0]         = swint_q;
            default:    rd_val            = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_RESP;
                    err_d   = dec_err ? RSP_ERR_DECODE : RSP_OK;
                    rdata_d = (!REQ_WRITE && !dec_err) ? rd_val : 32'h0;
                end
            end
            ST_RESP: begin
                if (RSP_READY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            warm_q  <= '0;
            prev_q  <= '0;
            edge_q  <= '0;
            mask_q  <= '0;
            swint_q <= 1'b0;
            irq_q   <= 1'b0;
            state_q <= ST_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            warm_q  <= warm_d;
            prev_q  <= sync_val;
            edge_q  <= edge_d;
            mask_q  <= mask_d;
            swint_q <= swint_d;
            irq_q   <= irq_d;
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign REQ_READY    = (state_q == ST_IDLE);
    assign RSP_VALID    = (state_q == ST_RESP);
    assign RSP_RDATA    = rdata_q;
    assign RSP_ERR      = err_q;
    assign BInterrupt06 = irq_q;
    assign dbg_state_o  = state_q;

endmodule
